scrypt_nonce_dispatcher: RTL and testbench
==========================================

# scrypt_nonce_dispatcher

Work-dispatch front end for `scrypt_top`. It accepts a 640-bit block header from the host side and owns the `enable`/`data` → `hash_done`/`match_found` interface of the core. It sweeps the 32-bit nonce field one hash at a time and reports the first nonce for which the core signals a match. It raises `exhausted` if the sweep wraps past 32'hFFFFFFFF without a match.

## Interface
- `NONCE_LSB`, 608: bit position of the 32-bit nonce field, `data[NONCE_LSB +: 32]`.
- `CONTINUE_ON_MATCH`, 0: 1 = resume the sweep after a result is acked; 0 = return to IDLE after the ack.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `n_rst`  in  1  reset; asynchronous, active-low.
- `work_valid`  in  1  host presents a new header.
- `work_data`  in  640  header; its nonce field is the starting nonce.
- `work_ready`  out  1  high only in IDLE; a transfer happens when `work_valid & work_ready` at an edge.
- `abort`  in  1  synchronous cancel of the current job.
- `core_enable`  out  1  one-cycle start pulse to `scrypt_top.enable`.
- `core_data`  out  640  header with the current nonce inserted, to `scrypt_top.data`.
- `core_hash_done`  in  1  from `scrypt_top.hash_done`.
- `core_match_found`  in  1  from `scrypt_top.match_found`; valid only with `core_hash_done`.
- `result_valid`  out  1  a winning nonce is held.
- `result_nonce`  out  32  the winning nonce.
- `result_ack`  in  1  host consumes the result.
- `exhausted`  out  1  one-cycle pulse when the sweep ends without a match.
- `busy`  out  1  high in any state other than IDLE.
- `hash_count`  out  32  hashes completed for the current job; wraps modulo 2^32.

## Operation
- States are IDLE, LAUNCH, WAIT and REPORT. All outputs come from registers or are decoded from the registered state.
- **IDLE**
  - `work_ready`=1.
  - On a transfer: latch `work_data` into the header register, set `nonce` = `work_data[NONCE_LSB+:32]`, clear `hash_count`, go to LAUNCH.
- **LAUNCH**
  - `core_enable`=1 for exactly this one cycle, then go to WAIT.
  - `core_data` = header with the nonce field replaced by `nonce`.
  - `core_data` stays stable from LAUNCH until the next nonce update.
- **WAIT**
  - `core_hash_done` is ignored unless the state is WAIT.
  - On `core_hash_done`, `hash_count` increments.
  - If `core_match_found`: go to REPORT and load `result_nonce` = `nonce`.
  - Else if `nonce` = 32'hFFFFFFFF: pulse `exhausted`, go to IDLE.
  - Else: increment `nonce` and `core_data` at the same edge, go to LAUNCH.
- **REPORT**
  - `result_valid`=1, held until `result_ack` is sampled high.
  - On ack with `CONTINUE_ON_MATCH`=0: go to IDLE.
  - On ack with `CONTINUE_ON_MATCH`=1: if `nonce` = FFFFFFFF, pulse `exhausted` and go to IDLE; else increment `nonce` and go to LAUNCH.
  - `result_ack` outside REPORT has no effect.
- **Abort**
  - `abort` high at an edge in any state forces IDLE and clears `result_valid`. `core_enable` is 0 next cycle.
  - `abort` outranks every other event in the same cycle, including `core_hash_done` and a work transfer.
  - A `hash_done` that arrives later for the aborted job is ignored, because the block is no longer in WAIT.
- **Nonce arithmetic**: unsigned 32-bit. The compare against FFFFFFFF happens before the increment, so the nonce never wraps to 0 within a job.

## Timing
- **Reset values**: state IDLE, `work_ready`=1, `core_enable`=0, `core_data`=0, `result_valid`=0, `result_nonce`=0, `exhausted`=0, `busy`=0, `hash_count`=0.
- **Reset mid-operation**: same values immediately, asynchronously; any pending result is lost.
- **Start latency**: a transfer at edge k gives `core_enable` high from edge k to edge k+1.
- **Relaunch latency**: `core_hash_done` (no match) sampled at edge m gives `core_enable` high for cycle m..m+1 with the incremented nonce.
- **Match reporting**: match sampled at edge m gives `result_valid` from edge m.
- **Ack turnaround**: ack at edge a drops `result_valid` from edge a. With `CONTINUE_ON_MATCH`=1, `core_enable` is high for cycle a..a+1.
- **Exhausted pulse**: exactly one cycle, concurrent with the return to IDLE. `work_ready` rises in the same cycle.

## Test plan
- **Basic launch**: reset; header of all bytes 8'h01, so nonce is 32'h01010101; `work_valid` for 1 cycle → `core_enable` one pulse one cycle later, `core_data[639:608]`=32'h01010101, `busy`=1.
- **Sweep then match**: model returns `hash_done` after 5 cycles with no match 3 times, then a match → enables for nonces 01010101..01010104; `result_nonce`=32'h01010104; `hash_count`=4; `result_valid` held until ack, then IDLE.
- **Exhaustion**: start nonce FFFFFFFE, both hashes no match → exactly 2 launches, one `exhausted` pulse, `work_ready`=1, no wrap to 0.
- **Continue mode**: `CONTINUE_ON_MATCH`=1, match on nonce 10, ack 3 cycles later → relaunch with nonce 11 the cycle after the ack.
- **Abort**: `abort` in WAIT on the same edge as `hash_done` → IDLE, no result, `hash_count` unchanged; a late `hash_done` is ignored.
- **Reset mid-REPORT**: `n_rst` low while `result_valid`=1 → all outputs at reset values with no clock edge.

Source files
------------

// File: rtl/scrypt_nonce_dispatcher.sv
// Work-dispatch front end for scrypt_top: sweeps the 32-bit nonce field of a
// 640-bit header one hash at a time and reports the first matching nonce.
module scrypt_nonce_dispatcher #(
    parameter int NONCE_LSB         = 608,
    parameter bit CONTINUE_ON_MATCH = 1'b0
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         work_valid,
    input  logic [639:0] work_data,
    output logic         work_ready,
    input  logic         abort,
    output logic         core_enable,
    output logic [639:0] core_data,
    input  logic         core_hash_done,
    input  logic         core_match_found,
    output logic         result_valid,
    output logic [31:0]  result_nonce,
    input  logic         result_ack,
    output logic         exhausted,
    output logic         busy,
    output logic [31:0]  hash_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t        state_r;
    logic          core_enable_r;
    logic [639:0]  core_data_r;
    logic [31:0]   nonce_r;
    logic          result_valid_r;
    logic [31:0]   result_nonce_r;
    logic          exhausted_r;
    logic [31:0]   hash_count_r;

    logic          nonce_last_s;
    logic [31:0]   nonce_inc_s;

    function automatic logic [639:0] insert_nonce(input logic [639:0] hdr,
                                                  input logic [31:0]  nonce);
        logic [639:0] tmp;
        tmp                    = hdr;
        tmp[NONCE_LSB +: 32]   = nonce;
        return tmp;
    endfunction

    // The end-of-range test uses the current nonce, so the sweep never wraps to 0.
    always_comb begin
        nonce_last_s = (nonce_r == 32'hFFFF_FFFF);
        nonce_inc_s  = nonce_r + 32'd1;
    end

    // Dispatcher state machine with all job-visible registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r        <= ST_IDLE;
            core_enable_r  <= 1'b0;
            core_data_r    <= 640'd0;
            nonce_r        <= 32'd0;
            result_valid_r <= 1'b0;
            result_nonce_r <= 32'd0;
            exhausted_r    <= 1'b0;
            hash_count_r   <= 32'd0;
        end else begin
            core_enable_r <= 1'b0;
            exhausted_r   <= 1'b0;
            if (abort) begin
                state_r        <= ST_IDLE;
                result_valid_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (work_valid) begin
                            core_data_r   <= work_data;
                            nonce_r       <= work_data[NONCE_LSB +: 32];
                            hash_count_r  <= 32'd0;
                            core_enable_r <= 1'b1;
                            state_r       <= ST_LAUNCH;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_LAUNCH: begin
                        state_r <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (core_hash_done) begin
                            hash_count_r <= hash_count_r + 32'd1;
                            if (core_match_found) begin
                                result_valid_r <= 1'b1;
                                result_nonce_r <= nonce_r;
                                state_r        <= ST_REPORT;
                            end else if (nonce_last_s) begin
                                exhausted_r <= 1'b1;
                                state_r     <= ST_IDLE;
                            end else begin
                                nonce_r       <= nonce_inc_s;
                                core_data_r   <= insert_nonce(core_data_r, nonce_inc_s);
                                core_enable_r <= 1'b1;
                                state_r       <= ST_LAUNCH;
                            end
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                    ST_REPORT: begin
                        if (result_ack) begin
                            result_valid_r <= 1'b0;
                            if (CONTINUE_ON_MATCH == 1'b0) begin
                                state_r <= ST_IDLE;
                            end else if (nonce_last_s) begin
                                exhausted_r <= 1'b1;
                                state_r     <= ST_IDLE;
                            end else begin
                                nonce_r       <= nonce_inc_s;
                                core_data_r   <= insert_nonce(core_data_r, nonce_inc_s);
                                core_enable_r <= 1'b1;
                                state_r       <= ST_LAUNCH;
                            end
                        end else begin
                            state_r <= ST_REPORT;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign work_ready   = (state_r == ST_IDLE);
    assign busy         = (state_r != ST_IDLE);
    assign core_enable  = core_enable_r;
    assign core_data    = core_data_r;
    assign result_valid = result_valid_r;
    assign result_nonce = result_nonce_r;
    assign exhausted    = exhausted_r;
    assign hash_count   = hash_count_r;

endmodule

// File: tb/tb_scrypt_nonce_dispatcher.sv
// Directed self-checking bench for scrypt_nonce_dispatcher (stop-on-match and
// continue-on-match instances).
module tb_scrypt_nonce_dispatcher;

    logic         clk;
    logic         n_rst;

    logic         a_work_valid, a_abort, a_hash_done, a_match, a_ack;
    logic [639:0] a_work_data;
    logic         a_work_ready, a_core_enable, a_result_valid, a_exhausted, a_busy;
    logic [639:0] a_core_data;
    logic [31:0]  a_result_nonce, a_hash_count;

    logic         b_work_valid, b_abort, b_hash_done, b_match, b_ack;
    logic [639:0] b_work_data;
    logic         b_work_ready, b_core_enable, b_result_valid, b_exhausted, b_busy;
    logic [639:0] b_core_data;
    logic [31:0]  b_result_nonce, b_hash_count;

    int           n_checks;
    int           n_errors;
    int           enable_cnt;
    logic [639:0] hdr;

    scrypt_nonce_dispatcher u_dut (
        .clk(clk), .n_rst(n_rst),
        .work_valid(a_work_valid), .work_data(a_work_data), .work_ready(a_work_ready),
        .abort(a_abort), .core_enable(a_core_enable), .core_data(a_core_data),
        .core_hash_done(a_hash_done), .core_match_found(a_match),
        .result_valid(a_result_valid), .result_nonce(a_result_nonce), .result_ack(a_ack),
        .exhausted(a_exhausted), .busy(a_busy), .hash_count(a_hash_count)
    );

    scrypt_nonce_dispatcher #(.NONCE_LSB(608), .CONTINUE_ON_MATCH(1'b1)) u_dut_cont (
        .clk(clk), .n_rst(n_rst),
        .work_valid(b_work_valid), .work_data(b_work_data), .work_ready(b_work_ready),
        .abort(b_abort), .core_enable(b_core_enable), .core_data(b_core_data),
        .core_hash_done(b_hash_done), .core_match_found(b_match),
        .result_valid(b_result_valid), .result_nonce(b_result_nonce), .result_ack(b_ack),
        .exhausted(b_exhausted), .busy(b_busy), .hash_count(b_hash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge; counts launches of instance A.
    task automatic tick();
        @(posedge clk);
        #1;
        if (a_core_enable === 1'b1) enable_cnt++;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; enable_cnt = 0;
        n_rst = 1'b0;
        a_work_valid = 1'b0; a_work_data = 640'd0; a_abort = 1'b0;
        a_hash_done = 1'b0; a_match = 1'b0; a_ack = 1'b0;
        b_work_valid = 1'b0; b_work_data = 640'd0; b_abort = 1'b0;
        b_hash_done = 1'b0; b_match = 1'b0; b_ack = 1'b0;

        #12;
        check_val("rst_work_ready",   {63'd0, a_work_ready},   64'd1);
        check_val("rst_busy",         {63'd0, a_busy},         64'd0);
        check_val("rst_core_enable",  {63'd0, a_core_enable},  64'd0);
        check_val("rst_core_data",    {63'd0, (a_core_data == 640'd0)}, 64'd1);
        check_val("rst_result_valid", {63'd0, a_result_valid}, 64'd0);
        check_val("rst_hash_count",   {32'd0, a_hash_count},   64'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // Basic launch
        hdr = {80{8'h01}};
        a_work_data = hdr; a_work_valid = 1'b1;
        tick();
        a_work_valid = 1'b0;
        check_val("launch_enable",     {63'd0, a_core_enable}, 64'd1);
        check_val("launch_nonce",      {32'd0, a_core_data[639:608]}, 64'h01010101);
        check_val("launch_header",     {63'd0, (a_core_data == hdr)}, 64'd1);
        check_val("launch_busy",       {63'd0, a_busy}, 64'd1);
        check_val("launch_work_ready", {63'd0, a_work_ready}, 64'd0);
        tick();
        check_val("launch_pulse_end",  {63'd0, a_core_enable}, 64'd0);

        // Sweep: three misses, then a match on the fourth nonce
        for (int i = 0; i < 4; i++) begin
            repeat (4) tick();
            check_val("wait_no_enable", {63'd0, a_core_enable}, 64'd0);
            a_hash_done = 1'b1; a_match = (i == 3);
            tick();
            a_hash_done = 1'b0; a_match = 1'b0;
            if (i < 3) begin
                check_val("relaunch_enable", {63'd0, a_core_enable}, 64'd1);
                check_val("relaunch_nonce", {32'd0, a_core_data[639:608]}, 64'h01010101 + 64'(i + 1));
                check_val("relaunch_header_low", {63'd0, (a_core_data[607:0] == hdr[607:0])}, 64'd1);
                tick();
            end
        end
        check_val("match_valid",      {63'd0, a_result_valid}, 64'd1);
        check_val("match_nonce",      {32'd0, a_result_nonce}, 64'h01010104);
        check_val("match_hash_count", {32'd0, a_hash_count},   64'd4);
        repeat (2) tick();
        check_val("match_held",       {63'd0, a_result_valid}, 64'd1);
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        check_val("ack_valid_drop",   {63'd0, a_result_valid}, 64'd0);
        check_val("ack_idle",         {63'd0, a_work_ready},   64'd1);
        check_val("ack_no_relaunch",  {63'd0, a_core_enable},  64'd0);
        a_hash_done = 1'b1;
        tick();
        a_hash_done = 1'b0;
        check_val("idle_done_ignored", {32'd0, a_hash_count}, 64'd4);

        // Exhaustion
        hdr = 640'd0;
        hdr[639:608] = 32'hFFFF_FFFE;
        a_work_data = hdr; a_work_valid = 1'b1; enable_cnt = 0;
        tick();
        a_work_valid = 1'b0;
        check_val("exh_first_nonce", {32'd0, a_core_data[639:608]}, 64'hFFFFFFFE);
        check_val("exh_count_clear", {32'd0, a_hash_count}, 64'd0);
        tick();
        a_hash_done = 1'b1;
        tick();
        a_hash_done = 1'b0;
        check_val("exh_second_nonce", {32'd0, a_core_data[639:608]}, 64'hFFFFFFFF);
        tick();
        a_hash_done = 1'b1;
        tick();
        a_hash_done = 1'b0;
        check_val("exh_pulse",       {63'd0, a_exhausted},  64'd1);
        check_val("exh_work_ready",  {63'd0, a_work_ready}, 64'd1);
        check_val("exh_no_wrap",     {32'd0, a_core_data[639:608]}, 64'hFFFFFFFF);
        check_val("exh_hash_count",  {32'd0, a_hash_count}, 64'd2);
        tick();
        check_val("exh_pulse_end",   {63'd0, a_exhausted},  64'd0);
        check_val("exh_launches",    64'(enable_cnt), 64'd2);

        // Abort on the same edge as hash_done, then a late hash_done
        hdr = 640'd0;
        hdr[639:608] = 32'h0000_0010;
        a_work_data = hdr; a_work_valid = 1'b1;
        tick();
        a_work_valid = 1'b0;
        tick();
        a_hash_done = 1'b1; a_abort = 1'b1;
        tick();
        a_hash_done = 1'b0; a_abort = 1'b0;
        check_val("abort_idle",       {63'd0, a_busy},         64'd0);
        check_val("abort_no_result",  {63'd0, a_result_valid}, 64'd0);
        check_val("abort_count_kept", {32'd0, a_hash_count},   64'd0);
        check_val("abort_no_enable",  {63'd0, a_core_enable},  64'd0);
        a_hash_done = 1'b1;
        tick();
        a_hash_done = 1'b0;
        check_val("late_done_count",  {32'd0, a_hash_count},   64'd0);
        check_val("late_done_idle",   {63'd0, a_busy},         64'd0);
        a_work_valid = 1'b1; a_abort = 1'b1;
        tick();
        a_work_valid = 1'b0; a_abort = 1'b0;
        check_val("abort_beats_work", {63'd0, a_busy},         64'd0);

        // Reset while a result is held
        hdr[639:608] = 32'h0000_0020;
        a_work_data = hdr; a_work_valid = 1'b1;
        tick();
        a_work_valid = 1'b0;
        tick();
        a_hash_done = 1'b1; a_match = 1'b1;
        tick();
        a_hash_done = 1'b0; a_match = 1'b0;
        check_val("pre_rst_valid",    {63'd0, a_result_valid}, 64'd1);
        check_val("pre_rst_nonce",    {32'd0, a_result_nonce}, 64'h20);
        #2;
        n_rst = 1'b0;
        #1;
        check_val("mid_rst_valid",    {63'd0, a_result_valid}, 64'd0);
        check_val("mid_rst_nonce",    {32'd0, a_result_nonce}, 64'd0);
        check_val("mid_rst_data",     {63'd0, (a_core_data == 640'd0)}, 64'd1);
        check_val("mid_rst_count",    {32'd0, a_hash_count},   64'd0);
        check_val("mid_rst_busy",     {63'd0, a_busy},         64'd0);
        check_val("mid_rst_ready",    {63'd0, a_work_ready},   64'd1);
        @(negedge clk);
        n_rst = 1'b1;

        // Continue-on-match instance: match on nonce 10, ack three cycles later
        hdr = 640'd0;
        hdr[639:608] = 32'd10;
        b_work_data = hdr; b_work_valid = 1'b1;
        tick();
        b_work_valid = 1'b0;
        check_val("cont_launch_nonce", {32'd0, b_core_data[639:608]}, 64'd10);
        tick();
        b_hash_done = 1'b1; b_match = 1'b1;
        tick();
        b_hash_done = 1'b0; b_match = 1'b0;
        check_val("cont_match_valid",  {63'd0, b_result_valid}, 64'd1);
        check_val("cont_match_nonce",  {32'd0, b_result_nonce}, 64'd10);
        repeat (3) tick();
        check_val("cont_no_enable",    {63'd0, b_core_enable},  64'd0);
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        check_val("cont_ack_drop",     {63'd0, b_result_valid}, 64'd0);
        check_val("cont_relaunch",     {63'd0, b_core_enable},  64'd1);
        check_val("cont_next_nonce",   {32'd0, b_core_data[639:608]}, 64'd11);
        check_val("cont_busy",         {63'd0, b_busy},         64'd1);
        check_val("cont_count",        {32'd0, b_hash_count},   64'd1);
        b_abort = 1'b1;
        tick();
        b_abort = 1'b0;
        check_val("cont_abort_idle",   {63'd0, b_work_ready},   64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
